// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU sequencer.
// A restoring shift-subtract datapath runs one quotient bit per cycle under a
// three-state FSM (IDLE, CALC, DONE). Divide-by-zero and signed overflow
// finish in a single cycle without iterating.
// Optional build macro: DIV_UNIT_EARLY_OUT_EN also takes the single-cycle path
// when the dividend magnitude is below the divisor magnitude.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dataS1,
    input  logic [XLEN-1:0] dataS2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] COUNT_INIT = CW'(XLEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] divisor_q;
    logic            op_rem;
    logic            neg_q;
    logic            neg_r;

    logic            is_signed;
    logic            is_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic            early;
    logic            special;
    logic [XLEN-1:0] special_result;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            fits;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] final_result;

    // Decode the incoming request: operand magnitudes, result signs and the
    // cases that can be answered without iterating.
    always_comb begin
        is_signed = ~op[0];
        is_rem    = op[1];
        a_neg     = is_signed & dataS1[XLEN-1];
        b_neg     = is_signed & dataS2[XLEN-1];
        a_mag     = a_neg ? (~dataS1 + 1'b1) : dataS1;
        b_mag     = b_neg ? (~dataS2 + 1'b1) : dataS2;
        div_zero  = (dataS2 == '0);
        overflow  = is_signed && (dataS1 == MOST_NEG) && (dataS2 == '1);
`ifdef DIV_UNIT_EARLY_OUT_EN
        early     = !div_zero && (a_mag < b_mag);
`else
        early     = 1'b0;
`endif
        special   = div_zero | overflow | early;

        special_result = '0;
        if (div_zero) begin
            special_result = is_rem ? dataS1 : '1;
        end else if (overflow) begin
            special_result = is_rem ? '0 : MOST_NEG;
        end else begin
            special_result = is_rem ? dataS1 : '0;
        end
    end

    // One restoring step: shift in the next dividend bit, trial-subtract the
    // divisor and keep the difference only when it did not go negative.
    always_comb begin
        shifted  = {rem_q, quo_q[XLEN-1]};
        diff     = shifted - {1'b0, divisor_q};
        fits     = ~diff[XLEN];
        rem_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_next = {quo_q[XLEN-2:0], fits};
        if (op_rem) begin
            final_result = neg_r ? (~rem_next + 1'b1) : rem_next;
        end else begin
            final_result = neg_q ? (~quo_next + 1'b1) : quo_next;
        end
    end

    // FSM and datapath registers; result only changes on the edge into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            op_rem    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_rem    <= is_rem;
                        neg_q     <= a_neg ^ b_neg;
                        neg_r     <= a_neg;
                        divisor_q <= b_mag;
                        quo_q     <= a_mag;
                        rem_q     <= '0;
                        count     <= COUNT_INIT;
                        if (special) begin
                            result <= special_result;
                            state  <= ST_DONE;
                        end else begin
                            state  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        result <= final_result;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_CALC);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
// Cycle 0 is the edge that samples an accepted start; outputs are sampled on
// the falling edge of each following cycle.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dataS1;
    logic [31:0] dataS2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checkCount = 0;
    int passCount  = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_UNIT_EARLY_OUT_EN
    localparam int EARLY_DONE = 1;
`else
    localparam int EARLY_DONE = 33;
`endif

    div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .dataS1 (dataS1),
        .dataS2 (dataS2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if it disagrees
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one operation and check completion timing, result and busy shape.
    // A non-zero injectCycle drives a competing DIVU 9/3 start on that edge.
    task automatic applyStimulus(input string tag, input logic [1:0] opIn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expResult, input int expDone,
                                 input int injectCycle);
        int          doneCycle;
        int          busyCycles;
        int          overlap;
        logic [31:0] got;
        doneCycle  = 0;
        busyCycles = 0;
        overlap    = 0;
        got        = '0;
        @(negedge clk);
        op     = opIn;
        dataS1 = a;
        dataS2 = b;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) busyCycles++;
            if (busy && done) overlap++;
            if (done) begin
                doneCycle = c;
                got       = result;
                break;
            end
            if (injectCycle != 0 && c == injectCycle - 1) begin
                op     = OP_DIVU;
                dataS1 = 32'd9;
                dataS2 = 32'd3;
                start  = 1'b1;
            end else begin
                start  = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput({tag, " done_cycle"}, doneCycle, expDone);
        checkOutput({tag, " result"}, got, expResult);
        checkOutput({tag, " busy_cycles"}, busyCycles, expDone - 1);
        checkOutput({tag, " busy_done_overlap"}, overlap, 0);
        @(negedge clk);
        checkOutput({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
        checkOutput({tag, " result_held"}, result, expResult);
    endtask

    // Directed sequence
    initial begin
        int donePulses;
        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        dataS1 = '0;
        dataS2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        rst = 1'b0;

        applyStimulus("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
        applyStimulus("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
        applyStimulus("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0);
        applyStimulus("rem_m7_2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0);
        applyStimulus("rem_7_m2", OP_REM, 32'd7, 32'hFFFFFFFE, 32'd1, 33, 0);
        applyStimulus("div_min_2", OP_DIV, 32'h80000000, 32'd2, 32'hC0000000, 33, 0);
        applyStimulus("divu_max_1", OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33, 0);
        applyStimulus("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
        applyStimulus("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 1, 0);
        applyStimulus("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        applyStimulus("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 0);
        applyStimulus("divu_3_10", OP_DIVU, 32'd3, 32'd10, 32'd0, EARLY_DONE, 0);
        applyStimulus("remu_3_10", OP_REMU, 32'd3, 32'd10, 32'd3, EARLY_DONE, 0);
        applyStimulus("rem_m3_10", OP_REM, 32'hFFFFFFFD, 32'd10, 32'hFFFFFFFD, EARLY_DONE, 0);
        applyStimulus("start_ignored", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 10);

        // Reset during an iteration aborts it with no completion pulse
        @(negedge clk);
        op     = OP_DIVU;
        dataS1 = 32'd100;
        dataS2 = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        checkOutput("abort result", result, 32'd0);
        rst = 1'b0;
        donePulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) donePulses++;
        end
        checkOutput("abort no_done", donePulses, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
